// File: rtl/pulse_index_decoder.sv
`timescale 1ns/1ps
// pulse_index_decoder
// Accepts a binary line index and drives the matching one-hot output line for
// HOLD cycles. It then forces GAP idle cycles and signals completion with a
// one-cycle done pulse. Out-of-range indices set a sticky err flag instead.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-high reset
//   in_valid - request strobe; in_idx is valid
//   in_idx   - binary index of the line to pulse (IW bits)
//   in_ready - high in IDLE; a request is accepted on in_valid & in_ready
//   err_clr  - synchronous clear of err (a new error on the same edge wins)
//   w        - one-hot output, all zeros when not driving
//   busy     - high whenever not IDLE
//   done     - one-cycle pulse on the first IDLE cycle after a pulse sequence
//   err      - sticky out-of-range flag
module pulse_index_decoder #(
  parameter int unsigned N    = 4,
  parameter int unsigned HOLD = 2,
  parameter int unsigned GAP  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [$clog2(N)-1:0] in_idx,
  output logic                 in_ready,
  input  logic                 err_clr,
  output logic [N-1:0]         w,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned IW        = $clog2(N);
  localparam int unsigned XW        = IW + 1;
  localparam int unsigned HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int unsigned GW        = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned HOLD_LOAD = HOLD - 1;
  localparam int unsigned GAP_LOAD  = (GAP > 0) ? GAP - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

  state_t          r_state, w_nxt_state;
  logic [IW-1:0]   r_idx, w_nxt_idx;
  logic [HW-1:0]   r_hold, w_nxt_hold;
  logic [GW-1:0]   r_gap, w_nxt_gap;
  logic            r_done, w_nxt_done;
  logic            r_err, w_nxt_err;
  logic            w_accept;
  logic            w_oor;

  // One extra bit so the range check stays meaningful when N is a power of two
  assign w_oor    = {1'b0, in_idx} >= XW'(N);
  assign w_accept = in_valid && (r_state == S_IDLE);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_hold  <= '0;
      r_gap   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_idx   <= w_nxt_idx;
      r_hold  <= w_nxt_hold;
      r_gap   <= w_nxt_gap;
      r_done  <= w_nxt_done;
      r_err   <= w_nxt_err;
    end
  end

  // Next-state, counter and flag logic
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_hold  = r_hold;
    w_nxt_gap   = r_gap;
    w_nxt_done  = 1'b0;
    w_nxt_err   = r_err;

    // Set takes priority over clear
    if (err_clr) w_nxt_err = 1'b0;
    if (w_accept && w_oor) w_nxt_err = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_oor) begin
          w_nxt_idx   = in_idx;
          w_nxt_hold  = HW'(HOLD_LOAD);
          w_nxt_state = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (r_hold == '0) begin
          if (GAP > 0) begin
            w_nxt_gap   = GW'(GAP_LOAD);
            w_nxt_state = S_GAP;
          end else begin
            w_nxt_state = S_IDLE;
            w_nxt_done  = 1'b1;
          end
        end else begin
          w_nxt_hold = r_hold - HW'(1);
        end
      end
      S_GAP: begin
        if (r_gap == '0) begin
          w_nxt_state = S_IDLE;
          w_nxt_done  = 1'b1;
        end else begin
          w_nxt_gap = r_gap - GW'(1);
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // State-derived outputs; reset clears them without waiting for an edge
  assign in_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);
  assign w        = (r_state == S_DRIVE) ? (N'(1) << r_idx) : '0;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_pulse_index_decoder.sv
`timescale 1ns/1ps
module tb_pulse_index_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // a: N=4 HOLD=2 GAP=1
  logic       a_valid = 1'b0, a_clr = 1'b0;
  logic [1:0] a_idx = '0;
  logic [3:0] a_w;
  logic       a_ready, a_busy, a_done, a_err;
  // b: N=4 HOLD=1 GAP=0
  logic       b_valid = 1'b0, b_clr = 1'b0;
  logic [1:0] b_idx = '0;
  logic [3:0] b_w;
  logic       b_ready, b_busy, b_done, b_err;
  // c: N=5 HOLD=2 GAP=1
  logic       c_valid = 1'b0, c_clr = 1'b0;
  logic [2:0] c_idx = '0;
  logic [4:0] c_w;
  logic       c_ready, c_busy, c_done, c_err;

  pulse_index_decoder #(.N(4), .HOLD(2), .GAP(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_idx(a_idx), .in_ready(a_ready),
    .err_clr(a_clr), .w(a_w), .busy(a_busy), .done(a_done), .err(a_err));

  pulse_index_decoder #(.N(4), .HOLD(1), .GAP(0)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_idx(b_idx), .in_ready(b_ready),
    .err_clr(b_clr), .w(b_w), .busy(b_busy), .done(b_done), .err(b_err));

  pulse_index_decoder #(.N(5), .HOLD(2), .GAP(1)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_idx(c_idx), .in_ready(c_ready),
    .err_clr(c_clr), .w(c_w), .busy(c_busy), .done(c_done), .err(c_err));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance past the next rising edge; outputs then show the new cycle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state while rst is held
    step();
    step();
    chk("rst_ready", 32'(a_ready), 1);
    chk("rst_busy",  32'(a_busy), 0);
    chk("rst_w",     32'(a_w), 0);
    chk("rst_done",  32'(a_done), 0);
    chk("rst_err",   32'(a_err), 0);
    rst = 1'b0;

    // Basic pulse on idx 2, accepted at the first edge after reset release
    a_valid = 1'b1; a_idx = 2'd2;
    step();                                   // k+1
    a_valid = 1'b0;
    chk("p2_w1",     32'(a_w), 32'h4);
    chk("p2_busy1",  32'(a_busy), 1);
    chk("p2_ready1", 32'(a_ready), 0);
    step();                                   // k+2
    chk("p2_w2",     32'(a_w), 32'h4);
    chk("p2_done2",  32'(a_done), 0);
    step();                                   // k+3 gap
    chk("p2_gap_w",  32'(a_w), 0);
    chk("p2_gap_bs", 32'(a_busy), 1);
    chk("p2_gap_dn", 32'(a_done), 0);
    step();                                   // k+4 done
    chk("p2_done",   32'(a_done), 1);
    chk("p2_ready",  32'(a_ready), 1);
    chk("p2_dn_w",   32'(a_w), 0);

    // Back-to-back: idx 0, then idx 3 in the done cycle
    a_valid = 1'b1; a_idx = 2'd0;
    step();
    a_valid = 1'b0;
    chk("bb0_w1", 32'(a_w), 32'h1);
    step();
    chk("bb0_w2", 32'(a_w), 32'h1);
    step();
    chk("bb0_gap", 32'(a_w), 0);
    step();
    chk("bb0_done", 32'(a_done), 1);
    a_valid = 1'b1; a_idx = 2'd3;
    step();
    a_valid = 1'b0;
    chk("bb3_w1",   32'(a_w), 32'h8);
    chk("bb3_dn1",  32'(a_done), 0);
    step();
    chk("bb3_w2",   32'(a_w), 32'h8);
    step();
    chk("bb3_gap",  32'({a_busy, a_w}), 32'h10);
    step();
    chk("bb3_done", 32'({a_done, a_ready}), 32'h3);

    // Inputs toggled during DRIVE are ignored
    a_valid = 1'b1; a_idx = 2'd1;
    step();
    chk("tg_w1", 32'(a_w), 32'h2);
    a_idx = 2'd3;
    step();
    chk("tg_w2", 32'(a_w), 32'h2);
    a_idx = 2'd0;
    step();
    a_valid = 1'b0;
    chk("tg_gap", 32'({a_busy, a_w}), 32'h10);
    step();
    chk("tg_done", 32'(a_done), 1);
    step();
    chk("tg_noacc", 32'({a_busy, a_w}), 0);

    // Asynchronous reset in the second DRIVE cycle
    a_valid = 1'b1; a_idx = 2'd2;
    step();
    a_valid = 1'b0;
    step();
    chk("ar_w_pre", 32'(a_w), 32'h4);
    #2 rst = 1'b1;
    #1;
    chk("ar_w",    32'(a_w), 0);
    chk("ar_busy", 32'(a_busy), 0);
    #1 rst = 1'b0;
    step();
    chk("ar_done1", 32'({a_done, a_busy}), 0);
    step();
    chk("ar_done2", 32'({a_done, a_busy}), 0);

    // GAP=0, HOLD=1
    b_valid = 1'b1; b_idx = 2'd1;
    step();
    b_valid = 1'b0;
    chk("g0_w",     32'(b_w), 32'h2);
    chk("g0_busy",  32'(b_busy), 1);
    step();
    chk("g0_w_off", 32'(b_w), 0);
    chk("g0_done",  32'({b_done, b_ready, b_busy}), 32'h6);
    step();
    chk("g0_done0", 32'(b_done), 0);

    // N=5: in-range top index, then out-of-range handling
    c_valid = 1'b1; c_idx = 3'd4;
    step();
    c_valid = 1'b0;
    chk("n5_w4", 32'(c_w), 32'h10);
    step(); step(); step();
    chk("n5_done", 32'(c_done), 1);
    c_valid = 1'b1; c_idx = 3'd6;
    step();
    c_valid = 1'b0;
    chk("oor_err",  32'(c_err), 1);
    chk("oor_idle", 32'({c_w, c_busy, c_done, c_ready}), 32'h1);
    step();
    chk("oor_stky", 32'({c_err, c_done, c_busy}), 32'h4);
    c_clr = 1'b1;
    step();
    c_clr = 1'b0;
    chk("clr_err", 32'(c_err), 0);
    c_valid = 1'b1; c_idx = 3'd7; c_clr = 1'b1;
    step();
    c_valid = 1'b0; c_clr = 1'b0;
    chk("set_win", 32'(c_err), 1);
    chk("set_idle", 32'({c_busy, c_w}), 0);
    step();
    chk("set_hold", 32'(c_err), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit so the bench always terminates
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/pulse_index_decoder.md
PULSE_INDEX_DECODER -- requirements
Module: pulse_index_decoder

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of one-hot output lines; legal range is N >= 2.
REQ-002 The block SHALL have parameter HOLD, default 2, giving the number of cycles an output line is driven; legal range is HOLD >= 1.
REQ-003 The block SHALL have parameter GAP, default 1, giving the number of forced-idle cycles after each pulse; legal range is GAP >= 0.
REQ-004 The block SHALL define local width IW = $clog2(N) for the index input.
REQ-005 The ports SHALL be as follows, one per line, as name, direction, width and meaning:
- clk       input   1    sole clock; all state updates on the rising edge.
- rst       input   1    asynchronous, active-high reset.
- in_valid  input   1    in_idx is valid.
- in_idx    input   IW   binary index of the line to pulse, with bit 0 as the lowest line.
- in_ready  output  1    block accepts a request this cycle.
- err_clr   input   1    synchronous clear of err.
- w         output  N    one-hot decoded output; all zeros when not driving.
- busy      output  1    high when the state is not IDLE.
- done      output  1    one-cycle pulse when a pulse sequence completes.
- err       output  1    sticky flag indicating an out-of-range index was received.

Function
REQ-006 The block SHALL implement the states IDLE, DRIVE and GAP, and all outputs SHALL be registered or derived from state only.
REQ-007 A request SHALL be accepted on a rising edge at which in_valid and in_ready are both 1.
REQ-008 The in_ready output SHALL be 1 only in IDLE.
REQ-009 The busy output SHALL equal (state != IDLE).
REQ-010 On accepting a request with in_idx < N, the block SHALL:
- capture in_idx;
- load a hold counter with HOLD-1;
- enter DRIVE.
REQ-011 On accepting a request with in_idx >= N, the block SHALL:
- set err;
- leave w at all zeros;
- stay in IDLE;
- not assert done;
- treat the request as consumed.
REQ-012 In DRIVE, w SHALL equal exactly (1 << captured index), with every other bit 0.
REQ-013 In DRIVE, the hold counter SHALL decrement each cycle.
REQ-014 DRIVE SHALL last exactly HOLD cycles.
REQ-015 When the hold counter is 0 in DRIVE, the block SHALL go to GAP with the gap counter loaded with GAP-1 if GAP > 0, and to IDLE otherwise.
REQ-016 In GAP, w SHALL be all zeros and the gap counter SHALL decrement.
REQ-017 GAP SHALL last exactly GAP cycles, after which the block SHALL enter IDLE.
REQ-018 The done output SHALL be 1 for exactly the first cycle in IDLE following a DRIVE or GAP, and 0 otherwise.
REQ-019 The latency SHALL be as follows for a request accepted at edge k:
- w is valid in cycles k+1 .. k+HOLD;
- gap cycles are k+HOLD+1 .. k+HOLD+GAP;
- in_ready and done are 1 in cycle k+HOLD+GAP+1.
REQ-020 A new request presented in the done cycle SHALL be accepted, giving back-to-back throughput of one pulse per HOLD+GAP+1 cycles.
REQ-021 The in_valid and in_idx inputs SHALL be ignored while in_ready is 0.
REQ-022 Captured in_idx SHALL NOT be affected by input changes during DRIVE.
REQ-023 The err output SHALL remain 1 until err_clr is sampled 1.
REQ-024 If an out-of-range acceptance and err_clr occur on the same edge, err SHALL be 1, so set wins over clear.
REQ-025 The err_clr input SHALL have no effect on state, w, busy or done.
REQ-026 The hold and gap counters SHALL each be wide enough for their maximum load value and SHALL never wrap.
REQ-027 When GAP = 0, the GAP state SHALL be unreachable.

Reset
REQ-028 While rst is 1, the block SHALL asynchronously force:
- state to IDLE;
- w to 0;
- busy, done and err to 0;
- in_ready to 1;
- counters and the captured index to 0.
REQ-029 Reset asserted mid-DRIVE or mid-GAP SHALL clear w immediately without waiting for a clock edge.
REQ-030 Reset asserted mid-DRIVE or mid-GAP SHALL NOT produce a done pulse after release.
REQ-031 The first rising edge after rst deasserts SHALL be able to accept a request.

Verification
REQ-032 The bench SHALL cover this scenario (N=4, HOLD=2, GAP=1): in_idx=2 accepted at edge k -> w=4'b0100 in cycles k+1 and k+2, w=0 with busy=1 in k+3, and done=1 with in_ready=1 in k+4.
REQ-033 The bench SHALL cover this back-to-back scenario: idx 0, then idx 3 presented in the done cycle -> w=0001 for 2 cycles, 1 gap cycle, then w=1000 for 2 cycles, with no lost request.
REQ-034 The bench SHALL cover this out-of-range scenario (N=5, IW=3): in_idx=6 accepted -> err=1, w=0, state stays IDLE, no done; then err_clr=1 -> err=0 next cycle; then simultaneous in_idx=7 acceptance and err_clr -> err stays 1.
REQ-035 The bench SHALL cover this scenario (GAP=0, HOLD=1): idx 1 at edge k -> w=0010 in k+1 only, and done with in_ready in k+2.
REQ-036 The bench SHALL cover this reset scenario: rst pulsed asynchronously during the second DRIVE cycle -> w=0 and busy=0 before the next edge, and no done after release.
REQ-037 The bench SHALL cover this scenario: in_idx toggled with in_valid=1 during DRIVE -> w unchanged and no extra acceptance.
